// File: rtl/core_pkg.sv
// Shared core definitions: hazard controller state encodings and register-index width.
package core_pkg;

   localparam int CORE_REG_ADDR_WIDTH = 5;

   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_REDIRECT = 2'd1,
      HZ_MEMWAIT  = 2'd2
   } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + WIDTH'(1);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, fetch and data-memory waits,
// plus saturating stall/flush counters.
module hazard_ctrl
   import core_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = CORE_REG_ADDR_WIDTH,
   parameter int CNT_WIDTH      = 32,
   parameter int FLUSH_CYCLES   = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
   input  logic [REG_ADDR_WIDTH-1:0] rd_e,
   input  logic                      load_e,
   input  logic                      pc_src_e,
   input  logic                      imem_ready,
   input  logic                      dmem_ready,
   output logic                      stall_pc,
   output logic                      stall_fd,
   output logic                      flush_fd,
   output logic                      stall_de,
   output logic                      flush_de,
   output logic                      stall_em,
   output logic [1:0]                state_o,
   output logic [CNT_WIDTH-1:0]      stall_count,
   output logic [CNT_WIDTH-1:0]      flush_count
);

   localparam int RC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   hz_state_t state, state_nxt, ret, ret_nxt, eff;
   logic [RC_W-1:0] rcnt, rcnt_nxt;
   logic load_use, flush_inc;

   assign load_use = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
   // MEM_WAIT is transparent: the release cycle behaves as the state held before the freeze
   assign eff      = (state == HZ_MEMWAIT) ? ret : state;
   assign state_o  = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= HZ_RUN;
         ret   <= HZ_RUN;
         rcnt  <= '0;
      end else begin
         state <= state_nxt;
         ret   <= ret_nxt;
         rcnt  <= rcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ret_nxt   = ret;
      rcnt_nxt  = rcnt;
      stall_pc  = 1'b0;
      stall_fd  = 1'b0;
      flush_fd  = 1'b0;
      stall_de  = 1'b0;
      flush_de  = 1'b0;
      stall_em  = 1'b0;
      flush_inc = 1'b0;

      if (!dmem_ready) begin
         stall_pc  = 1'b1;
         stall_fd  = 1'b1;
         stall_de  = 1'b1;
         stall_em  = 1'b1;
         state_nxt = HZ_MEMWAIT;
         if (state != HZ_MEMWAIT)
            ret_nxt = state;
      end else if (pc_src_e) begin
         flush_fd  = 1'b1;
         flush_de  = 1'b1;
         flush_inc = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_nxt = HZ_REDIRECT;
            rcnt_nxt  = RC_W'(FLUSH_CYCLES - 1);
         end else begin
            state_nxt = HZ_RUN;
            rcnt_nxt  = '0;
         end
      end else if (load_use) begin
         stall_pc  = 1'b1;
         stall_fd  = 1'b1;
         flush_de  = 1'b1;
         state_nxt = eff;
      end else if ((eff == HZ_REDIRECT) && (rcnt != '0)) begin
         flush_fd  = 1'b1;
         rcnt_nxt  = rcnt - RC_W'(1);
         state_nxt = (rcnt == RC_W'(1)) ? HZ_RUN : HZ_REDIRECT;
      end else if (!imem_ready) begin
         stall_pc  = 1'b1;
         flush_fd  = 1'b1;
         state_nxt = HZ_RUN;
      end else begin
         state_nxt = HZ_RUN;
      end

      // Clear the downstream registers on every edge while reset is held
      if (!rst_n) begin
         stall_pc  = 1'b0;
         stall_fd  = 1'b0;
         stall_de  = 1'b0;
         stall_em  = 1'b0;
         flush_fd  = 1'b1;
         flush_de  = 1'b1;
         flush_inc = 1'b0;
      end
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_pc),
      .count (stall_count)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_inc),
      .count (flush_count)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (FLUSH_CYCLES=3, CNT_WIDTH=4).
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] rs1_d, rs2_d, rd_e;
   logic       load_e, pc_src_e, imem_ready, dmem_ready;
   logic       stall_pc, stall_fd, flush_fd, stall_de, flush_de, stall_em;
   logic [1:0] state_o;
   logic [3:0] stall_count, flush_count;
   logic [5:0] ctrl;

   int unsigned errors = 0;
   int unsigned checks = 0;

   // ctrl = {stall_pc, stall_fd, flush_fd, stall_de, flush_de, stall_em}
   localparam logic [5:0] C_IDLE   = 6'b000000;
   localparam logic [5:0] C_RESET  = 6'b001010;
   localparam logic [5:0] C_LDUSE  = 6'b110010;
   localparam logic [5:0] C_BRANCH = 6'b001010;
   localparam logic [5:0] C_REDIR  = 6'b001000;
   localparam logic [5:0] C_FREEZE = 6'b110101;
   localparam logic [5:0] C_FETCH  = 6'b101000;

   hazard_ctrl #(
      .REG_ADDR_WIDTH (5),
      .CNT_WIDTH      (4),
      .FLUSH_CYCLES   (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rs1_d       (rs1_d),
      .rs2_d       (rs2_d),
      .rd_e        (rd_e),
      .load_e      (load_e),
      .pc_src_e    (pc_src_e),
      .imem_ready  (imem_ready),
      .dmem_ready  (dmem_ready),
      .stall_pc    (stall_pc),
      .stall_fd    (stall_fd),
      .flush_fd    (flush_fd),
      .stall_de    (stall_de),
      .flush_de    (flush_de),
      .stall_em    (stall_em),
      .state_o     (state_o),
      .stall_count (stall_count),
      .flush_count (flush_count)
   );

   assign ctrl = {stall_pc, stall_fd, flush_fd, stall_de, flush_de, stall_em};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rs1_d      = 5'd1;
      rs2_d      = 5'd2;
      rd_e       = 5'd0;
      load_e     = 1'b0;
      pc_src_e   = 1'b0;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      #2;
      check("rst_ctrl", 32'(ctrl), 32'(C_RESET));
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_stall_cnt", 32'(stall_count), 32'd0);
      check("rst_flush_cnt", 32'(flush_count), 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("idle_ctrl", 32'(ctrl), 32'(C_IDLE));

      // load-use on rs2
      load_e = 1'b1; rd_e = 5'd5; rs2_d = 5'd5;
      #1;
      check("lu_ctrl", 32'(ctrl), 32'(C_LDUSE));
      tick();
      load_e = 1'b0;
      #1;
      check("lu_after", 32'(ctrl), 32'(C_IDLE));
      check("lu_stall_cnt", 32'(stall_count), 32'd1);

      // rd_e = 0 never stalls
      idle_inputs();
      load_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0;
      #1;
      check("rd0_ctrl", 32'(ctrl), 32'(C_IDLE));

      // taken branch, three F/D bubbles
      do_reset();
      pc_src_e = 1'b1;
      #1;
      check("br0_ctrl", 32'(ctrl), 32'(C_BRANCH));
      check("br0_state", 32'(state_o), 32'd0);
      tick();
      pc_src_e = 1'b0;
      #1;
      check("br1_ctrl", 32'(ctrl), 32'(C_REDIR));
      check("br1_state", 32'(state_o), 32'd1);
      tick();
      check("br2_ctrl", 32'(ctrl), 32'(C_REDIR));
      check("br2_state", 32'(state_o), 32'd1);
      tick();
      check("br3_ctrl", 32'(ctrl), 32'(C_IDLE));
      check("br3_state", 32'(state_o), 32'd0);
      check("br_flush_cnt", 32'(flush_count), 32'd1);

      // data-memory freeze in the middle of a redirect
      do_reset();
      pc_src_e = 1'b1;
      tick();
      pc_src_e   = 1'b0;
      dmem_ready = 1'b0;
      #1;
      for (int unsigned i = 0; i < 4; i++) begin
         check($sformatf("frz%0d_ctrl", i), 32'(ctrl), 32'(C_FREEZE));
         check($sformatf("frz%0d_state", i), 32'(state_o), (i == 0) ? 32'd1 : 32'd2);
         tick();
      end
      dmem_ready = 1'b1;
      #1;
      check("res0_ctrl", 32'(ctrl), 32'(C_REDIR));
      check("res0_state", 32'(state_o), 32'd2);
      tick();
      check("res1_ctrl", 32'(ctrl), 32'(C_REDIR));
      check("res1_state", 32'(state_o), 32'd1);
      tick();
      check("res2_ctrl", 32'(ctrl), 32'(C_IDLE));
      check("res2_state", 32'(state_o), 32'd0);
      check("frz_stall_cnt", 32'(stall_count), 32'd4);
      check("frz_flush_cnt", 32'(flush_count), 32'd1);

      // branch and load-use together: flush wins
      do_reset();
      load_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7; pc_src_e = 1'b1;
      #1;
      check("sim_ctrl", 32'(ctrl), 32'(C_BRANCH));
      tick();
      idle_inputs();
      #1;
      check("sim_stall_cnt", 32'(stall_count), 32'd0);
      check("sim_flush_cnt", 32'(flush_count), 32'd1);

      // fetch wait for two cycles
      do_reset();
      imem_ready = 1'b0;
      #1;
      check("fw0_ctrl", 32'(ctrl), 32'(C_FETCH));
      tick();
      check("fw1_ctrl", 32'(ctrl), 32'(C_FETCH));
      tick();
      imem_ready = 1'b1;
      #1;
      check("fw_after", 32'(ctrl), 32'(C_IDLE));
      check("fw_stall_cnt", 32'(stall_count), 32'd2);

      // asynchronous reset while frozen
      do_reset();
      dmem_ready = 1'b0;
      tick();
      tick();
      check("mw_state", 32'(state_o), 32'd2);
      check("mw_stall_cnt", 32'(stall_count), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_state", 32'(state_o), 32'd0);
      check("arst_stall_cnt", 32'(stall_count), 32'd0);
      check("arst_ctrl", 32'(ctrl), 32'(C_RESET));
      dmem_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      #1;
      check("arst_after_ctrl", 32'(ctrl), 32'(C_IDLE));
      tick();
      check("arst_after_state", 32'(state_o), 32'd0);

      // saturation of the 4-bit stall counter
      do_reset();
      dmem_ready = 1'b0;
      repeat (14) tick();
      check("sat14", 32'(stall_count), 32'd14);
      repeat (6) tick();
      check("sat20", 32'(stall_count), 32'd15);
      dmem_ready = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage core. It drives the stall (`en`, active-high hold) and clear (`clr`) inputs of the F/D and D/E pipeline registers and the PC hold. It resolves load-use hazards, taken-branch redirects, instruction-fetch wait states and data-memory wait states. It also keeps saturating stall and flush counters for performance analysis.

## Interface
- `REG_ADDR_WIDTH`, default 5: register-index width.
- `CNT_WIDTH`, default 32: width of each performance counter.
- `FLUSH_CYCLES`, default 1: bubble cycles inserted after a taken branch (≥1).
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `rs1_d`, `rs2_d` in `REG_ADDR_WIDTH`: source registers of the instruction in D.
- `rd_e` in `REG_ADDR_WIDTH`: destination register in E.
- `load_e` in 1: the instruction in E is a load.
- `pc_src_e` in 1: a taken branch or jump is resolved in E.
- `imem_ready` in 1: instruction memory returns valid `instr_f` this cycle.
- `dmem_ready` in 1: data memory completes (or is not needed) this cycle.
- `stall_pc` out 1: hold the PC register.
- `stall_fd` out 1: to F/D `en`; 1 holds the register.
- `flush_fd` out 1: to F/D `clr`.
- `stall_de` out 1: hold the D/E register.
- `flush_de` out 1: to D/E `clr`.
- `stall_em` out 1: hold E/M and M/W.
- `state_o` out 2: current FSM state encoding.
- `stall_count` out `CNT_WIDTH`: cycles with `stall_pc`=1.
- `flush_count` out `CNT_WIDTH`: taken-branch redirects accepted.

## Operation
- FSM states: RUN=0, REDIRECT=1, MEM_WAIT=2.
- Control outputs are combinational from state and inputs. State and counters are registered.
- Per-cycle priority, highest first:
  1. **`dmem_ready`=0** (any state): freeze. All stall outputs are 1 and both flushes are 0. Go to or stay in MEM_WAIT. The redirect counter holds.
  2. **`pc_src_e`=1**: `flush_fd`=1, `flush_de`=1, stalls 0. `flush_count`++.
     - If `FLUSH_CYCLES`>1: enter REDIRECT and load the counter with `FLUSH_CYCLES`-1.
     - A `pc_src_e` seen in REDIRECT restarts the counter.
  3. **Load-use**: condition is `load_e` && `rd_e`≠0 && (`rd_e`==`rs1_d` || `rd_e`==`rs2_d`).
     - Response: `stall_pc`=1, `stall_fd`=1, `flush_de`=1. Exactly one bubble.
  4. **REDIRECT with counter>0**: `flush_fd`=1. Decrement. Return to RUN when the counter reaches 1 on the current cycle.
  5. **`imem_ready`=0**: `stall_pc`=1, `flush_fd`=1 (bubble into D), D/E and later stages advance.
- MEM_WAIT returns to the state held before the freeze (RUN or REDIRECT) on the first cycle with `dmem_ready`=1. That cycle is evaluated normally by priorities 2–5.
- Counters saturate at all-ones and never wrap.
- `stall_count` increments on every cycle with `stall_pc`=1, including freezes.

## Timing
- Reset (`rst_n`=0):
  - State is RUN, counters are 0, redirect counter is 0.
  - `flush_fd`=`flush_de`=1 and all stalls are 0, so the downstream registers clear on each edge during reset.
- Reset mid-REDIRECT or mid-MEM_WAIT abandons the operation immediately with no residual bubble.
- Load-use latency: one stall cycle. On the next cycle `load_e` has cleared because a bubble is in E.
- A taken branch costs `FLUSH_CYCLES`+1 bubbles total: two flushed slots on the resolve cycle, plus `FLUSH_CYCLES`-1 additional F/D flushes.
- Simultaneous load-use and `pc_src_e`: the flush wins and no stall is issued.
- `rd_e`=0 never produces a stall.

## Structure
- The shared package `core_pkg` holds the state encodings (`HZ_RUN`, `HZ_REDIRECT`, `HZ_MEMWAIT`) and the `REG_ADDR_WIDTH` default.
- One natural sub-module is `sat_counter` (parameterised width, increment enable, saturating, async active-low reset). It is instantiated twice.

## Test plan
- **Load-use:** `load_e`=1, `rd_e`=5, `rs2_d`=5, `dmem_ready`=`imem_ready`=1.
  - Required: one cycle of `stall_pc`=`stall_fd`=`flush_de`=1, then all 0.
  - `stall_count`=1.
- **Branch with `FLUSH_CYCLES`=3:** `pc_src_e` pulsed for 1 cycle.
  - Required: `flush_fd`=1 for 3 consecutive cycles and `flush_de`=1 on the first only.
  - `state_o` follows 0→1→1→0. `flush_count`=1.
- **Data-memory freeze during REDIRECT:** `dmem_ready`=0 for 4 cycles.
  - Required: all stalls 1 and no flushes for 4 cycles.
  - The redirect resumes with its remaining count intact.
  - `stall_count`=4.
- **Simultaneous hazards:** `pc_src_e`=1 together with a load-use match.
  - Required: `flush_fd`=`flush_de`=1, `stall_pc`=0.
- **Fetch wait:** `imem_ready`=0 for 2 cycles.
  - Required: `stall_pc`=`flush_fd`=1 for 2 cycles, `stall_de`=0.
- **Reset and saturation:**
  - Assert `rst_n`=0 mid-MEM_WAIT. Required: `state_o`=0 and counters 0 asynchronously.
  - Force a counter to all-ones (`CNT_WIDTH`=4) and continue stalling. Required: it stays at 15.
